control_block: RTL and testbench
================================

CONTROL_BLOCK -- requirements
Module: control_block

Interface
REQ-001 SHALL have no parameters; widths fixed: data 24, MCU word 13, command 3, image length 10, status 32.
REQ-002 SHALL use one clock and an asynchronous, active-low reset.
REQ-003 i_CLK  in  1  sole clock; all state updates on its rising edge.
REQ-004 i_rst  in  1  asynchronous, active-low reset.
REQ-005 i_GPIOctrl  in  3  command code: 0 Kernel_load, 1 ImgSize_load, 2 Img_load, 3 Data_request, 4 LoadFinish_goToRun; 5-7 reserved.
REQ-006 i_GPIOvalid  in  1  software strobe, level-type; its low-to-high transition marks a new command/data word.
REQ-007 i_GPIOdata  in  24  command payload.
REQ-008 i_MCUdata  in  13  result word returned from memory.
REQ-009 i_EOP_from_FSM  in  1  end-of-processing pulse from the address sequencer.
REQ-010 o_KNLdata  out  24  latched kernel column: three signed 8-bit taps, [7:0] row0, [15:8] row1, [23:16] row2.
REQ-011 o_imgLength  out  10  latched image length.
REQ-012 o_MCUdata  out  13  latched result word.
REQ-013 o_GPIOdata  out  32  status word.
REQ-014 o_load  out  1  image-load mode level.
REQ-015 o_run  out  1  start-of-processing pulse.
REQ-016 o_valid_to_FSM  out  1  one-cycle address-advance pulse.
REQ-017 o_valid_to_CONV  out  1  one-cycle kernel-shift pulse.
REQ-018 o_KNorIMG  out  1  0 = kernel path, 1 = image path.
REQ-019 o_EOP_to_MCU  out  1  sticky end-of-processing flag.

Function
REQ-020 SHALL register i_GPIOvalid; edge = i_GPIOvalid AND NOT previous sample; all actions below fire only on an edge.
REQ-021 Outputs SHALL be registered; edge detected in cycle N gives updated data and pulses in cycle N+1; pulses last exactly one cycle.
REQ-022 Command 0 edge: o_KNLdata <= i_GPIOdata, o_valid_to_CONV pulse; three edges load a full 3x3 kernel.
REQ-023 Command 1 edge: o_imgLength <= i_GPIOdata[9:0]; no pulses.
REQ-024 Command 2 edge: o_valid_to_FSM pulse.
REQ-025 Command 3 edge: o_MCUdata <= i_MCUdata, o_valid_to_FSM pulse.
REQ-026 Command 4 edge: o_run pulse and o_EOP_to_MCU cleared; further edges while command stays 4 re-issue o_run.
REQ-027 Commands 5-7 SHALL cause no latch update and no pulse.
REQ-028 o_load SHALL be 1 while registered command is 2, else 0; o_KNorIMG SHALL be 0 while registered command is 0, else 1; both follow i_GPIOctrl with one cycle of latency, independent of edges.
REQ-029 i_EOP_from_FSM=1 SHALL set o_EOP_to_MCU next cycle; held until reset or a command-4 edge; on a simultaneous set and clear, set wins.
REQ-030 o_GPIOdata SHALL be: [12:0] o_MCUdata, [13] o_EOP_to_MCU, [16:14] registered command, [31:17] zero.
REQ-031 A command change without an edge SHALL only affect o_load, o_KNorIMG and status bits [16:14].

Reset
REQ-032 i_rst low SHALL immediately zero all outputs and registers, except the valid-history register, which is set to 1 so a strobe held high through reset generates no edge.
REQ-033 Reset asserted mid-operation SHALL abort any pulse; after release, the first action requires a fresh low-to-high strobe.

Structure
REQ-034 A shared package SHALL hold the five command codes and widths 24/13/10/32.
REQ-035 One sub-module, valid_edge_detect (strobe register plus rising-edge output), is natural; the rest stays flat.

Verification
REQ-036 Reset with i_GPIOvalid=1, release -> no pulses, all outputs 0, o_KNorIMG=0.
REQ-037 ctrl=0, data 0x030201, strobe 0->1 -> next cycle o_KNLdata=0x030201, o_valid_to_CONV one-cycle pulse; strobe held high -> no further pulse.
REQ-038 ctrl=1, data 0x0000C8, strobe -> o_imgLength=200, no pulses; ctrl=2 -> o_load=1, o_KNorIMG=1; three strobes -> three o_valid_to_FSM pulses.
REQ-039 ctrl=4, strobe -> single o_run pulse; i_EOP_from_FSM pulse -> o_EOP_to_MCU=1 and o_GPIOdata[13]=1 until next command-4 edge.
REQ-040 ctrl=3, i_MCUdata=0x1ABC, strobe -> o_MCUdata=0x1ABC, o_GPIOdata[12:0]=0x1ABC, one o_valid_to_FSM pulse; ctrl=6 with strobe -> nothing changes except status bits [16:14]=6.

Source files
------------

// File: rtl/control_block_pkg.sv
// Shared widths and command codes for the GPIO control block.
package control_block_pkg;

  localparam int DATA_W = 24;
  localparam int MCU_W  = 13;
  localparam int CMD_W  = 3;
  localparam int LEN_W  = 10;
  localparam int STAT_W = 32;

  localparam logic [CMD_W-1:0] CMD_KERNEL_LOAD  = 3'd0;
  localparam logic [CMD_W-1:0] CMD_IMGSIZE_LOAD = 3'd1;
  localparam logic [CMD_W-1:0] CMD_IMG_LOAD     = 3'd2;
  localparam logic [CMD_W-1:0] CMD_DATA_REQUEST = 3'd3;
  localparam logic [CMD_W-1:0] CMD_GO_TO_RUN    = 3'd4;

endpackage

// File: rtl/control_block_valid_edge_detect.sv
// Registers the software strobe and flags its low-to-high transition.
module valid_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic valid_i,
  output logic edge_o
);

  logic valid_q;

  // History resets high so a strobe held through reset is not seen as new.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) valid_q <= 1'b1;
    else         valid_q <= valid_i;
  end

  assign edge_o = valid_i & ~valid_q;

endmodule

// File: rtl/control_block.sv
// GPIO command decoder: latches kernel/length/result words and issues
// one-cycle control pulses to the address sequencer and convolution core.
module control_block
  import control_block_pkg::*;
(
  input  logic              i_CLK,
  input  logic              i_rst,
  input  logic [CMD_W-1:0]  i_GPIOctrl,
  input  logic              i_GPIOvalid,
  input  logic [DATA_W-1:0] i_GPIOdata,
  input  logic [MCU_W-1:0]  i_MCUdata,
  input  logic              i_EOP_from_FSM,
  output logic [DATA_W-1:0] o_KNLdata,
  output logic [LEN_W-1:0]  o_imgLength,
  output logic [MCU_W-1:0]  o_MCUdata,
  output logic [STAT_W-1:0] o_GPIOdata,
  output logic              o_load,
  output logic              o_run,
  output logic              o_valid_to_FSM,
  output logic              o_valid_to_CONV,
  output logic              o_KNorIMG,
  output logic              o_EOP_to_MCU
);

  logic              edge_w;
  logic [CMD_W-1:0]  ctrl_q;
  logic [DATA_W-1:0] knl_q,   knl_d;
  logic [LEN_W-1:0]  len_q,   len_d;
  logic [MCU_W-1:0]  mcu_q,   mcu_d;
  logic              eop_q,   eop_d;
  logic              run_q,   run_d;
  logic              vfsm_q,  vfsm_d;
  logic              vconv_q, vconv_d;

  valid_edge_detect u_edge (
    .clk_i   (i_CLK),
    .rst_ni  (i_rst),
    .valid_i (i_GPIOvalid),
    .edge_o  (edge_w)
  );

  // Decode the command present at the strobe edge into latch updates and pulses.
  always_comb begin
    knl_d   = knl_q;
    len_d   = len_q;
    mcu_d   = mcu_q;
    eop_d   = eop_q;
    run_d   = 1'b0;
    vfsm_d  = 1'b0;
    vconv_d = 1'b0;
    if (edge_w) begin
      case (i_GPIOctrl)
        CMD_KERNEL_LOAD: begin
          knl_d   = i_GPIOdata;
          vconv_d = 1'b1;
        end
        CMD_IMGSIZE_LOAD: len_d = i_GPIOdata[LEN_W-1:0];
        CMD_IMG_LOAD:     vfsm_d = 1'b1;
        CMD_DATA_REQUEST: begin
          mcu_d  = i_MCUdata;
          vfsm_d = 1'b1;
        end
        CMD_GO_TO_RUN: begin
          run_d = 1'b1;
          eop_d = 1'b0;
        end
        default: ;
      endcase
    end
    // A sequencer end-of-processing in the same cycle as a run restart wins.
    if (i_EOP_from_FSM) eop_d = 1'b1;
  end

  // Output and command registers; reset kills any in-flight pulse.
  always_ff @(posedge i_CLK or negedge i_rst) begin
    if (!i_rst) begin
      ctrl_q  <= '0;
      knl_q   <= '0;
      len_q   <= '0;
      mcu_q   <= '0;
      eop_q   <= 1'b0;
      run_q   <= 1'b0;
      vfsm_q  <= 1'b0;
      vconv_q <= 1'b0;
    end else begin
      ctrl_q  <= i_GPIOctrl;
      knl_q   <= knl_d;
      len_q   <= len_d;
      mcu_q   <= mcu_d;
      eop_q   <= eop_d;
      run_q   <= run_d;
      vfsm_q  <= vfsm_d;
      vconv_q <= vconv_d;
    end
  end

  assign o_KNLdata       = knl_q;
  assign o_imgLength     = len_q;
  assign o_MCUdata       = mcu_q;
  assign o_EOP_to_MCU    = eop_q;
  assign o_run           = run_q;
  assign o_valid_to_FSM  = vfsm_q;
  assign o_valid_to_CONV = vconv_q;
  // Mode levels track the registered command regardless of strobes.
  assign o_load          = (ctrl_q == CMD_IMG_LOAD);
  assign o_KNorIMG       = (ctrl_q != CMD_KERNEL_LOAD);
  assign o_GPIOdata      = {{(STAT_W-MCU_W-1-CMD_W){1'b0}}, ctrl_q, eop_q, mcu_q};

endmodule

// File: tb/tb_control_block.sv
// Randomized + directed bench for control_block against a command-level model.
module tb_control_block;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  ctrl = '0;
  logic        vld = 1'b1;
  logic [23:0] gdata = '0;
  logic [12:0] mdata = '0;
  logic        eop = 1'b0;

  logic [23:0] knl;
  logic [9:0]  len;
  logic [12:0] mcu;
  logic [31:0] stat;
  logic        load, run, vfsm, vconv, knorimg, eop_o;

  control_block dut (
    .i_CLK           (clk),
    .i_rst           (rst_n),
    .i_GPIOctrl      (ctrl),
    .i_GPIOvalid     (vld),
    .i_GPIOdata      (gdata),
    .i_MCUdata       (mdata),
    .i_EOP_from_FSM  (eop),
    .o_KNLdata       (knl),
    .o_imgLength     (len),
    .o_MCUdata       (mcu),
    .o_GPIOdata      (stat),
    .o_load          (load),
    .o_run           (run),
    .o_valid_to_FSM  (vfsm),
    .o_valid_to_CONV (vconv),
    .o_KNorIMG       (knorimg),
    .o_EOP_to_MCU    (eop_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model state: what software has written so far
  logic        m_pv;
  logic [2:0]  m_cmd;
  logic [23:0] m_knl;
  logic [9:0]  m_len;
  logic [12:0] m_mcu;
  logic        m_eop, m_run, m_vf, m_vc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pv = 1'b1; m_cmd = '0; m_knl = '0; m_len = '0; m_mcu = '0;
    m_eop = 1'b0; m_run = 1'b0; m_vf = 1'b0; m_vc = 1'b0;
  endtask

  // Advance the model by one clock using the inputs present before the edge.
  task automatic model_tick();
    logic new_word;
    if (!rst_n) begin
      model_reset();
    end else begin
      new_word = vld && !m_pv;
      m_run = 1'b0; m_vf = 1'b0; m_vc = 1'b0;
      if (new_word) begin
        if (ctrl == 3'd0) begin m_knl = gdata; m_vc = 1'b1; end
        if (ctrl == 3'd1) m_len = gdata[9:0];
        if (ctrl == 3'd2) m_vf = 1'b1;
        if (ctrl == 3'd3) begin m_mcu = mdata; m_vf = 1'b1; end
        if (ctrl == 3'd4) begin m_run = 1'b1; m_eop = 1'b0; end
      end
      if (eop) m_eop = 1'b1;
      m_pv  = vld;
      m_cmd = ctrl;
    end
  endtask

  task automatic check_all();
    chk("knl",     32'(knl),     32'(m_knl));
    chk("len",     32'(len),     32'(m_len));
    chk("mcu",     32'(mcu),     32'(m_mcu));
    chk("status",  stat,         (32'(m_cmd) << 14) | (32'(m_eop) << 13) | 32'(m_mcu));
    chk("load",    32'(load),    32'(m_cmd == 3'd2));
    chk("knorimg", 32'(knorimg), 32'(m_cmd != 3'd0));
    chk("run",     32'(run),     32'(m_run));
    chk("vfsm",    32'(vfsm),    32'(m_vf));
    chk("vconv",   32'(vconv),   32'(m_vc));
    chk("eop",     32'(eop_o),   32'(m_eop));
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      model_tick();
      @(posedge clk);
      #1;
      check_all();
    end
  endtask

  // One clean strobe: drop for a cycle, then raise.
  task automatic strobe();
    vld = 1'b0; step(1);
    vld = 1'b1; step(1);
  endtask

  initial begin
    model_reset();
    // reset with strobe held high
    #2 rst_n = 1'b0;
    #1 check_all();
    step(2);
    rst_n = 1'b1;
    step(3);

    // kernel column load; held strobe gives no extra pulse
    ctrl = 3'd0; gdata = 24'h030201; step(1);
    strobe();
    chk("knl_dir", 32'(knl), 32'h030201);
    step(3);

    // image length, then image-load mode with three advances
    ctrl = 3'd1; gdata = 24'h0000C8; step(1);
    strobe();
    chk("len_dir", 32'(len), 32'd200);
    ctrl = 3'd2; step(1);
    for (int k = 0; k < 3; k++) strobe();

    // run, then end-of-processing sticky until next run edge
    ctrl = 3'd4; step(1);
    strobe(); step(2);
    eop = 1'b1; step(1);
    eop = 1'b0; step(3);
    chk("eop_sticky", 32'(stat[13]), 32'd1);
    strobe();
    chk("eop_clr", 32'(eop_o), 32'd0);
    // simultaneous set and clear: set wins
    vld = 1'b0; step(1);
    vld = 1'b1; eop = 1'b1; step(1);
    eop = 1'b0; step(1);

    // result fetch, then reserved command
    ctrl = 3'd3; mdata = 13'h1ABC; step(1);
    strobe();
    chk("mcu_dir", 32'(stat[12:0]), 32'h1ABC);
    ctrl = 3'd6; gdata = 24'hFFFFFF; mdata = 13'h0155; step(1);
    strobe(); step(1);

    // reset mid-pulse aborts it; strobe held high afterwards is not new
    ctrl = 3'd0; gdata = 24'h00A5A5; step(1);
    vld = 1'b0; step(1);
    vld = 1'b1; step(1);
    #2 rst_n = 1'b0; model_reset();
    #1 check_all();
    step(1);
    rst_n = 1'b1;
    step(3);

    // randomized traffic with occasional resets
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) ctrl = 3'($urandom_range(0, 7));
      vld   = 1'($urandom);
      gdata = 24'($urandom);
      mdata = 13'($urandom);
      eop   = ($urandom_range(0, 9) == 0);
      rst_n = ($urandom_range(0, 79) != 0);
      step(1);
    end
    rst_n = 1'b1;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
